// File: rtl/spl_scheduler_if.sv
// Tagged sample handshake into the SPL scheduler.
// Master offers a channel-tagged sample, slave applies back-pressure.
interface spl_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int CHANS = 4
);
  localparam int CW = $clog2(CHANS);

  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_chan;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid, in_chan, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_chan, in_data,
    output in_ready
  );
endinterface

// File: rtl/spl_scheduler.sv
// Multi-channel SPL peak-hold scheduler: one shared abs/peak/decay
// datapath time-shared across CHANS peak registers.
module spl_scheduler #(
  parameter int WIDTH     = 16,
  parameter int CHANS     = 4,
  parameter int DECAY_DIV = 4096
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     clear,
  spl_scheduler_if.slave           s_in,
  input  logic [$clog2(CHANS)-1:0] rd_chan,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     decay_miss
);
  localparam int CW = $clog2(CHANS);
  localparam int PW = $clog2(DECAY_DIV);

  typedef enum logic [1:0] {
    IDLE, MAG, UPD, DECAY
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_en;
  logic [CW-1:0]    r_chan;
  logic [CW-1:0]    r_idx;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] r_peak [CHANS];
  logic [WIDTH-1:0] r_rd;
  logic [PW-1:0]    r_pre;
  logic             r_pend;
  logic             r_miss;

  logic w_xfer;
  logic w_start;
  logic w_upd;
  logic w_dec;
  logic w_last;
  logic w_done;
  logic w_tick;

  assign w_xfer  = s_in.in_valid && s_in.in_ready;
  assign w_start = (r_state == IDLE) && !clear
                   && !w_xfer && r_pend;
  assign w_last  = (r_idx == CW'(CHANS - 1));
  assign w_done  = w_dec && w_last;
  assign w_tick  = (r_pre == PW'(DECAY_DIV - 1));

  assign rd_data    = r_rd;
  assign decay_miss = r_miss;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_xfer)       w_next = MAG;
          else if (w_start) w_next = DECAY;
        end
        MAG:   w_next = UPD;
        UPD:   w_next = IDLE;
        DECAY: if (w_last) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // r_en keeps in_ready low until the first edge after reset release
  always_comb begin
    s_in.in_ready = 1'b0;
    w_upd         = 1'b0;
    w_dec         = 1'b0;
    unique case (r_state)
      IDLE:  s_in.in_ready = r_en && !clear;
      UPD:   w_upd = !clear;
      DECAY: w_dec = !clear;
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_chan <= '0;
      r_data <= '0;
      r_mag  <= '0;
      r_idx  <= '0;
      for (int i = 0; i < CHANS; i++) r_peak[i] <= '0;
    end else begin
      r_en <= 1'b1;
      if (clear) begin
        r_chan <= '0;
        r_data <= '0;
        r_mag  <= '0;
        r_idx  <= '0;
        for (int i = 0; i < CHANS; i++) r_peak[i] <= '0;
      end else begin
        if (w_xfer) begin
          r_chan <= s_in.in_chan;
          r_data <= s_in.in_data;
        end
        if (r_state == MAG)
          r_mag <= r_data[WIDTH-1] ? -r_data : r_data;
        if (w_upd && (r_mag >= r_peak[r_chan]))
          r_peak[r_chan] <= r_mag;
        if (w_start) r_idx <= '0;
        if (w_dec) begin
          if (r_peak[r_idx] != '0)
            r_peak[r_idx] <= r_peak[r_idx] - WIDTH'(1);
          r_idx <= r_idx + CW'(1);
        end
      end
    end
  end

  // A tick landing on sweep completion re-arms the pending flag
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_pend <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (clear) begin
        r_pend <= 1'b0;
        r_miss <= 1'b0;
      end else begin
        if (w_tick)      r_pend <= 1'b1;
        else if (w_done) r_pend <= 1'b0;
        if (w_tick && r_pend && !w_done) r_miss <= 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) r_rd <= '0;
    else        r_rd <= r_peak[rd_chan];
  end
endmodule

// File: tb/tb_spl_scheduler.sv
// Directed bench for spl_scheduler: sample path on a slow-decay
// instance, decay sweeps and deferral on a fast-decay instance.
module tb_spl_scheduler;
  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst_a, rst_b, clr_a, clr_b;
  logic [1:0]  ra_ch, rb_ch;
  logic [15:0] ra_d, rb_d;
  logic        miss_a, miss_b;
  int n_chk  = 0;
  int n_pass = 0;

  spl_scheduler_if #(.WIDTH(16), .CHANS(4)) ia ();
  spl_scheduler_if #(.WIDTH(16), .CHANS(4)) ib ();

  spl_scheduler #(.WIDTH(16), .CHANS(4), .DECAY_DIV(4096)) ua (
    .ck(ck), .rst_n(rst_a), .clear(clr_a), .s_in(ia),
    .rd_chan(ra_ch), .rd_data(ra_d), .decay_miss(miss_a)
  );

  spl_scheduler #(.WIDTH(16), .CHANS(4), .DECAY_DIV(16)) ub (
    .ck(ck), .rst_n(rst_b), .clear(clr_b), .s_in(ib),
    .rd_chan(rb_ch), .rd_data(rb_d), .decay_miss(miss_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_a(input logic [1:0] ch, input logic [15:0] d);
    int t = 0;
    @(negedge ck);
    while (ia.in_ready !== 1'b1 && t < 50) begin
      @(negedge ck);
      t++;
    end
    chk("a_ready_wait", 32'(ia.in_ready), 1);
    ia.in_chan  = ch;
    ia.in_data  = d;
    ia.in_valid = 1'b1;
    @(posedge ck);
    #1 ia.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] ch, input logic [15:0] d);
    int t = 0;
    @(negedge ck);
    while (ib.in_ready !== 1'b1 && t < 50) begin
      @(negedge ck);
      t++;
    end
    chk("b_ready_wait", 32'(ib.in_ready), 1);
    ib.in_chan  = ch;
    ib.in_data  = d;
    ib.in_valid = 1'b1;
    @(posedge ck);
    #1 ib.in_valid = 1'b0;
  endtask

  // Transfer on E0; ready low after E0,E1; peak visible after E3
  task automatic samp_a(input string tag, input logic [1:0] ch,
                        input logic [15:0] d, input int old_v,
                        input int new_v);
    @(negedge ck);
    ra_ch = ch;
    send_a(ch, d);
    @(negedge ck);
    chk({tag, "_rdy_mag"}, 32'(ia.in_ready), 0);
    @(negedge ck);
    chk({tag, "_rdy_upd"}, 32'(ia.in_ready), 0);
    @(negedge ck);
    chk({tag, "_rdy_idle"}, 32'(ia.in_ready), 1);
    chk({tag, "_rd_e2"}, 32'(ra_d), old_v);
    @(negedge ck);
    chk({tag, "_rd_e3"}, 32'(ra_d), new_v);
  endtask

  task automatic rd_a(input string tag, input logic [1:0] ch,
                      input int exp);
    @(negedge ck);
    ra_ch = ch;
    @(posedge ck);
    @(negedge ck);
    chk(tag, 32'(ra_d), exp);
  endtask

  task automatic rd_b(input string tag, input logic [1:0] ch,
                      input int exp);
    @(negedge ck);
    rb_ch = ch;
    @(posedge ck);
    @(negedge ck);
    chk(tag, 32'(rb_d), exp);
  endtask

  // Called at a negedge; returns at the first negedge after a sweep
  task automatic sweep_b(input string tag);
    int t = 0;
    int n = 0;
    while (ib.in_ready !== 1'b1 && t < 64) begin
      @(negedge ck);
      t++;
    end
    while (ib.in_ready !== 1'b0 && t < 64) begin
      @(negedge ck);
      t++;
    end
    while (ib.in_ready === 1'b0 && n < 64) begin
      @(negedge ck);
      n++;
    end
    chk(tag, 32'(n), 4);
  endtask

  initial begin
    int run;
    int maxrun;
    int lows;
    int t;
    rst_a = 1'b0;
    rst_b = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    ra_ch = 2'd2;
    rb_ch = 2'd0;
    ia.in_valid = 1'b0;
    ia.in_chan  = 2'd0;
    ia.in_data  = 16'd0;
    ib.in_valid = 1'b0;
    ib.in_chan  = 2'd0;
    ib.in_data  = 16'd0;
    #3;
    chk("rst_rd", 32'(ra_d), 0);
    chk("rst_miss", 32'(miss_a), 0);
    chk("rst_ready_low", 32'(ia.in_ready), 0);
    #9 rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge ck);
    @(negedge ck);
    chk("rst_ready_up", 32'(ia.in_ready), 1);

    samp_a("s100", 2'd2, 16'd100, 0, 100);
    samp_a("s-300", 2'd2, 16'hFED4, 100, 300);
    samp_a("s200", 2'd2, 16'd200, 300, 300);
    rd_a("ch0_zero", 2'd0, 0);
    rd_a("ch1_zero", 2'd1, 0);
    rd_a("ch3_zero", 2'd3, 0);

    samp_a("sneg_max", 2'd0, 16'h8000, 0, 'h8000);
    samp_a("spos_max", 2'd1, 16'h7FFF, 0, 'h7FFF);
    samp_a("szero", 2'd3, 16'h0000, 0, 0);
    rd_a("ch2_keep", 2'd2, 300);

    @(negedge ck);
    clr_a = 1'b1;
    @(posedge ck);
    #1 clr_a = 1'b0;
    rd_a("clr_ch0", 2'd0, 0);
    rd_a("clr_ch2", 2'd2, 0);

    ra_ch = 2'd1;
    send_a(2'd1, 16'd500);
    @(negedge ck);
    clr_a = 1'b1;
    #1 chk("clr_mag_rdy", 32'(ia.in_ready), 0);
    @(posedge ck);
    #1 clr_a = 1'b0;
    @(negedge ck);
    chk("clr_mag_idle", 32'(ia.in_ready), 1);
    repeat (3) @(negedge ck);
    chk("clr_mag_ch1", 32'(ra_d), 0);

    @(negedge ck);
    clr_a = 1'b1;
    ia.in_valid = 1'b1;
    ia.in_chan  = 2'd1;
    ia.in_data  = 16'd1000;
    #1 chk("clr_valid_rdy", 32'(ia.in_ready), 0);
    @(posedge ck);
    #1 clr_a = 1'b0;
    ia.in_valid = 1'b0;
    repeat (4) @(negedge ck);
    chk("clr_valid_ch1", 32'(ra_d), 0);
    chk("a_miss", 32'(miss_a), 0);

    @(negedge ck);
    rst_b = 1'b0;
    @(negedge ck);
    rst_b = 1'b1;
    send_b(2'd0, 16'd5);
    send_b(2'd2, 16'd1);
    send_b(2'd3, 16'hFFFD);
    sweep_b("sweep1_len");
    rd_b("dec1_ch0", 2'd0, 4);
    rd_b("dec1_ch1", 2'd1, 0);
    rd_b("dec1_ch2", 2'd2, 0);
    rd_b("dec1_ch3", 2'd3, 2);
    sweep_b("sweep2_len");
    sweep_b("sweep3_len");
    sweep_b("sweep4_len");
    sweep_b("sweep5_len");
    rd_b("dec5_ch0", 2'd0, 0);
    rd_b("dec5_ch1", 2'd1, 0);
    rd_b("dec5_ch2", 2'd2, 0);
    rd_b("dec5_ch3", 2'd3, 0);
    chk("dec_miss", 32'(miss_b), 0);
    sweep_b("sweep6_len");

    ib.in_valid = 1'b1;
    ib.in_chan  = 2'd1;
    ib.in_data  = 16'hFFF9;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge ck);
      if (ib.in_ready === 1'b0) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    ib.in_valid = 1'b0;
    chk("defer_maxlow", 32'(maxrun), 2);
    chk("defer_miss", 32'(miss_b), 1);
    sweep_b("deferred_len");
    chk("miss_sticky", 32'(miss_b), 1);
    @(negedge ck);
    clr_b = 1'b1;
    @(posedge ck);
    #1 clr_b = 1'b0;
    @(negedge ck);
    chk("clr_miss", 32'(miss_b), 0);

    rb_ch = 2'd0;
    send_b(2'd0, 16'd9);
    t = 0;
    @(negedge ck);
    while (ib.in_ready !== 1'b1 && t < 64) begin
      @(negedge ck);
      t++;
    end
    while (ib.in_ready !== 1'b0 && t < 64) begin
      @(negedge ck);
      t++;
    end
    chk("mid_in_sweep", 32'(ib.in_ready), 0);
    chk("mid_pre_nz", 32'(rb_d != 16'd0), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rd", 32'(rb_d), 0);
    chk("mid_rdy", 32'(ib.in_ready), 0);
    chk("mid_miss", 32'(miss_b), 0);
    #4 rst_b = 1'b1;
    @(posedge ck);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      if (ib.in_ready !== 1'b1) lows++;
    end
    chk("mid_no_pend", 32'(lows), 0);
    rd_b("mid_ch0", 2'd0, 0);
    rd_b("mid_ch3", 2'd3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
